video_gen: RTL and testbench
============================

VIDEO_GEN -- requirements
Module: video_gen

Interface
REQ-001 SHALL accept parameter H_TOTAL, default 800: total pixel clocks per line.
REQ-002 SHALL accept parameter H_ACTIVE, default 640: visible pixel clocks per line.
REQ-003 SHALL accept parameters H_FRONT_PORCH = 16 and H_SYNC_WIDTH = 96: pixel clocks after active before hsync asserts, and hsync length.
REQ-004 SHALL accept parameters V_TOTAL = 525, V_ACTIVE = 480, V_FRONT_PORCH = 10 and V_SYNC_WIDTH = 2: the same quantities in lines.
REQ-005 SHALL accept parameters COLS = 32 and ROWS = 16: text cells per row, and cell rows.
REQ-006 SHALL accept parameter LINES_PER_CHAR, default 28: scan lines per cell row.
REQ-007 SHALL accept parameters H_SCALE = 1 and V_SCALE = 1: log2 horizontal pixel repeat, and log2 glyph-row repeat.
REQ-008 SHALL accept parameter SYNC_POL, default 0: 0 gives active-low hsync/vsync, 1 gives active-high.
REQ-009 SHALL accept parameter BLINK_FRAMES, default 16: frames per cursor blink phase.
REQ-010 Port clk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-011 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-012 Port vram_addr, output, AW = clog2(COLS*ROWS) bits: cell address, row*COLS + col.
REQ-013 Port vram_data, input, 9 bits: cell byte; bit 8 = chunky graphics. Valid 1 clk after vram_addr.
REQ-014 Port crom_addr, output, 11 bits: {char[6:0], glyph_row[3:0]}.
REQ-015 Port crom_data, input, 8 bits: glyph row, MSB = leftmost pixel. Valid 1 clk after crom_addr.
REQ-016 Port cur_we, input, 1 bit: when high, load cursor registers.
REQ-017 Port cur_pos, input, AW bits: cursor cell address.
REQ-018 Port cur_en, input, 1 bit: cursor enable.
REQ-019 Ports hsync, vsync and csync, outputs, 1 bit each: sync outputs; csync = XNOR of the internal active-high hsync and vsync.
REQ-020 Port video, output, 1 bit: pixel out; 0 outside the character window.
REQ-021 Port frame_start, output, 1 bit: one-clk pulse when h=0 and v=0 is output.

Function
REQ-022 h counter SHALL run 0..H_TOTAL-1 and then wrap; on wrap, v counter SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-023 Internal hsync SHALL be asserted for h in [H_ACTIVE+H_FRONT_PORCH, H_ACTIVE+H_FRONT_PORCH+H_SYNC_WIDTH); vsync is the same rule on v.
REQ-024 Window offsets SHALL be derived: HB = (H_ACTIVE - COLS*8<<H_SCALE)/2 and VB = (V_ACTIVE - ROWS*LINES_PER_CHAR)/2; negative values are an elaboration error.
REQ-025 Window SHALL be h in [HB, HB + COLS*8<<H_SCALE) and v in [VB, VB + ROWS*LINES_PER_CHAR).
REQ-026 Column SHALL be (h-HB)>>(3+H_SCALE); pixel x = ((h-HB)>>H_SCALE)[2:0]; row and line_counter SHALL come from v-VB, with line_counter in 0..LINES_PER_CHAR-1.
REQ-027 Text cell (bit8=0): glyph_row = line_counter>>V_SCALE, truncated to 4 bits; pixel = crom_data[7-x].
REQ-028 Chunky cell (bit8=1): q = (line_counter*4)/LINES_PER_CHAR; pixel = bit (2q + (x>=4)) of vram_data.
REQ-029 Cursor cell: when cur_en=1, blink phase=1 and cell address equals cur_pos, pixel SHALL be inverted for every line of the cell.
REQ-030 Blink phase SHALL toggle every BLINK_FRAMES frames; frame counter wraps at BLINK_FRAMES-1.
REQ-031 cur_we SHALL take effect from the next clk; a write mid-frame SHALL affect subsequent cells only.
REQ-032 Internal address prefetch SHALL be such that every output (video, hsync, vsync, csync, frame_start) corresponds to counter value n-4 at cycle n, fixed latency 4; syncs and pixels stay mutually aligned.
REQ-033 Output polarity SHALL be applied at the output register; there SHALL be no combinational path from inputs to outputs.
REQ-034 Parameter sets: default gives VGA 512x448; H_TOTAL 384/H_ACTIVE 320/V_TOTAL 312/V_ACTIVE 288/LINES_PER_CHAR 16/H_SCALE 0/V_SCALE 0 gives composite 256x256.

Reset
REQ-035 rst_n=0 SHALL asynchronously clear h, v, line_counter, frame counter, blink phase, cur_pos and cur_en registers, and pipeline; video=0, frame_start=0, hsync=vsync=!SYNC_POL... (inactive level), csync=1.
REQ-036 After release, the first frame_start SHALL occur at clk 4, then every H_TOTAL*V_TOTAL clks; reset mid-frame SHALL restart from h=v=0.

Verification
REQ-037 Defaults, free run 2 frames -> frame_start period 420000 clks, hsync low 96 clks starting 660 clks after line start (+4 latency), vsync low 2 lines from line 490.
REQ-038 vram all 0x041, crom row = 0xF0 -> in window, per 16-clk cell, video 1 for 8 clks, 0 for 8; 0 outside h[68,580) (latency-adjusted).
REQ-039 Cell 0 = 0x105 (chunky, bits 0,2) -> lines 16-22: left 8 clks 1, right 0; lines 23-29: left 1; lines 30-43: 0.
REQ-040 cur_we with cur_pos=33, cur_en=1, vram 0x020, crom 0x00 -> cell (1,1) all 1s during blink-on frames 16-31, 0 during frames 0-15.
REQ-041 rst_n low for 3 clks mid-line 200 -> outputs at reset levels immediately; frame_start exactly 4 clks after release.
REQ-042 Composite parameter set -> frame period 119808 clks, window 256x256 starting h=32, v=16.

Source files
------------

// File: rtl/video_gen.sv
// video_gen: character-cell video generator with a fixed 4-clk fetch pipeline
// (timing counters -> vram fetch -> crom fetch -> output register).
// Ports: clk, rst_n (async, active low); vram_addr/vram_data and
// crom_addr/crom_data talk to synchronous 1-clk-latency memories;
// cur_we/cur_pos/cur_en load the cursor; hsync/vsync/csync/video/frame_start
// are registered outputs.
module video_gen #(
    parameter int H_TOTAL        = 800,
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_WIDTH   = 96,
    parameter int V_TOTAL        = 525,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_WIDTH   = 2,
    parameter int COLS           = 32,
    parameter int ROWS           = 16,
    parameter int LINES_PER_CHAR = 28,
    parameter int H_SCALE        = 1,
    parameter int V_SCALE        = 1,
    parameter int SYNC_POL       = 0,
    parameter int BLINK_FRAMES   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [$clog2(COLS*ROWS)-1:0]  vram_addr,
    input  logic [8:0]                    vram_data,
    output logic [10:0]                   crom_addr,
    input  logic [7:0]                    crom_data,
    input  logic                          cur_we,
    input  logic [$clog2(COLS*ROWS)-1:0]  cur_pos,
    input  logic                          cur_en,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          csync,
    output logic                          video,
    output logic                          frame_start
);

    localparam int AW    = $clog2(COLS * ROWS);
    localparam int HW    = $clog2(H_TOTAL + 1);
    localparam int VW    = $clog2(V_TOTAL + 1);
    localparam int LW    = $clog2(LINES_PER_CHAR + 1);
    localparam int RW    = $clog2(ROWS + 1);
    localparam int FW    = $clog2(BLINK_FRAMES + 1);
    localparam int WIN_W = (COLS * 8) << H_SCALE;
    localparam int WIN_H = ROWS * LINES_PER_CHAR;
    localparam int HB    = (H_ACTIVE - WIN_W) / 2;
    localparam int VB    = (V_ACTIVE - WIN_H) / 2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_WS   = HW'(HB);
    localparam logic [HW-1:0] H_WE   = HW'(HB + WIN_W);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_WS   = VW'(VB);
    localparam logic [VW-1:0] V_WE   = VW'(VB + WIN_H);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [LW-1:0] L_LAST = LW'(LINES_PER_CHAR - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic          POL    = (SYNC_POL != 0);

    if (H_ACTIVE < WIN_W || V_ACTIVE < WIN_H) begin : g_window_check
        $error("video_gen: character window exceeds active area");
    end

    // Per-pixel sideband carried down the fetch pipeline.
    typedef struct packed {
        logic       win;
        logic       cur;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] x;
    } side_t;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [RW-1:0] row_q, row_d;
    logic [LW-1:0] lc_q, lc_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          blink_q, blink_d;
    logic [AW-1:0] cpos_q;
    logic          cen_q;

    always_comb begin
        h_d     = h_q + 1'b1;
        v_d     = v_q;
        row_d   = row_q;
        lc_d    = lc_q;
        fc_d    = fc_q;
        blink_d = blink_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            // row/line tracking restarts at the window top; outside the
            // window it free-runs and is masked by the window test.
            if (v_d == V_WS) begin
                row_d = '0;
                lc_d  = '0;
            end else if (lc_q == L_LAST) begin
                lc_d  = '0;
                row_d = row_q + 1'b1;
            end else begin
                lc_d = lc_q + 1'b1;
            end
            if (v_q == V_LAST) begin
                if (fc_q == F_LAST) begin
                    fc_d    = '0;
                    blink_d = ~blink_q;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
            lc_q    <= '0;
            fc_q    <= '0;
            blink_q <= 1'b0;
            cpos_q  <= '0;
            cen_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            row_q   <= row_d;
            lc_q    <= lc_d;
            fc_q    <= fc_d;
            blink_q <= blink_d;
            if (cur_we) begin
                cpos_q <= cur_pos;
                cen_q  <= cur_en;
            end
        end
    end

    logic [HW-1:0] hrel;
    logic [31:0]   lc4;
    logic          win0, cur0, hs0, vs0, fs0;
    logic [AW-1:0] addr0;
    logic [2:0]    x0;
    logic [1:0]    q0;
    logic [3:0]    gr0;

    assign hrel  = h_q - H_WS;
    assign lc4   = 32'(lc_q) << 2;
    assign win0  = (h_q >= H_WS) && (h_q < H_WE) && (v_q >= V_WS) && (v_q < V_WE);
    assign addr0 = AW'(32'(row_q) * COLS + 32'(hrel >> (3 + H_SCALE)));
    assign cur0  = cen_q && blink_q && (addr0 == cpos_q);
    assign x0    = 3'(hrel >> H_SCALE);
    assign gr0   = 4'(lc_q >> V_SCALE);
    // Chunky quarter = floor(4*lc / LINES_PER_CHAR) via threshold compares.
    assign q0    = 2'(lc4 >= 32'(LINES_PER_CHAR))
                 + 2'(lc4 >= 32'(2 * LINES_PER_CHAR))
                 + 2'(lc4 >= 32'(3 * LINES_PER_CHAR));
    assign hs0   = (h_q >= H_SS) && (h_q < H_SE);
    assign vs0   = (v_q >= V_SS) && (v_q < V_SE);
    assign fs0   = (h_q == '0) && (v_q == '0);

    assign vram_addr = win0 ? addr0 : '0;

    side_t      s1, s2, s3;
    logic [1:0] q1;
    logic [3:0] gr1;
    logic       ch2, cb2, ch3, cb3;
    logic [10:0] crom_q;
    logic       video_q, fs_q, hs_q, vs_q, cs_q;
    logic       pix;

    assign pix = ch3 ? cb3 : crom_data[3'd7 - s3.x];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            q1      <= '0;
            gr1     <= '0;
            s2      <= '0;
            ch2     <= 1'b0;
            cb2     <= 1'b0;
            crom_q  <= '0;
            s3      <= '0;
            ch3     <= 1'b0;
            cb3     <= 1'b0;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= ~POL;
            vs_q    <= ~POL;
            cs_q    <= 1'b1;
        end else begin
            s1      <= {win0, cur0, hs0, vs0, fs0, x0};
            q1      <= q0;
            gr1     <= gr0;
            s2      <= s1;
            ch2     <= vram_data[8];
            cb2     <= vram_data[{q1, s1.x[2]}];
            crom_q  <= {vram_data[6:0], gr1};
            s3      <= s2;
            ch3     <= ch2;
            cb3     <= cb2;
            video_q <= s3.win & (pix ^ s3.cur);
            fs_q    <= s3.fs;
            hs_q    <= s3.hs ^ ~POL;
            vs_q    <= s3.vs ^ ~POL;
            cs_q    <= ~(s3.hs ^ s3.vs);
        end
    end

    assign crom_addr   = crom_q;
    assign video       = video_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign csync       = cs_q;

endmodule

// File: tb/tb_video_gen.sv
// tb_video_gen: random vram/crom/cursor stimulus on a shrunken timing set,
// every output compared each clock against an arithmetic reference model.
module tb_video_gen;

    localparam int HT    = 100;
    localparam int HA    = 80;
    localparam int HFP   = 4;
    localparam int HSW   = 8;
    localparam int VT    = 40;
    localparam int VA    = 32;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int LPC   = 8;
    localparam int HS    = 1;
    localparam int VS    = 1;
    localparam int SPOL  = 0;
    localparam int BF    = 2;
    localparam int AW    = $clog2(COLS * ROWS);
    localparam int FRAME = HT * VT;
    localparam int HB    = (HA - ((COLS * 8) << HS)) / 2;
    localparam int VB    = (VA - ROWS * LPC) / 2;
    localparam int WW    = (COLS * 8) << HS;
    localparam int WH    = ROWS * LPC;
    localparam int NMAX  = 32767;
    localparam logic POLB = (SPOL != 0);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] vram_addr;
    logic [8:0]    vram_data;
    logic [10:0]   crom_addr;
    logic [7:0]    crom_data;
    logic          cur_we;
    logic [AW-1:0] cur_pos;
    logic          cur_en;
    logic          hsync, vsync, csync, video, frame_start;

    logic [8:0]    vram [0:(1<<AW)-1];
    logic [7:0]    crom [0:2047];
    logic [AW-1:0] hist_pos [0:NMAX];
    logic          hist_en  [0:NMAX];

    int            vectors = 0;
    int            errors  = 0;
    int            n;
    logic [AW-1:0] mpos;
    logic          men;

    video_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
        .COLS(COLS), .ROWS(ROWS), .LINES_PER_CHAR(LPC),
        .H_SCALE(HS), .V_SCALE(VS), .SYNC_POL(SPOL), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vram_addr(vram_addr),
        .vram_data(vram_data),
        .crom_addr(crom_addr),
        .crom_data(crom_data),
        .cur_we(cur_we),
        .cur_pos(cur_pos),
        .cur_en(cur_en),
        .hsync(hsync),
        .vsync(vsync),
        .csync(csync),
        .video(video),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        crom_data <= crom[crom_addr];
    end

    task automatic cmp(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    // Expected {video, hsync, vsync, csync, frame_start} at cycle nn after
    // reset release; the outputs trail the raster position by 4 clocks.
    function automatic logic [4:0] model(input int nn);
        int p, f, r, h, v, col, x, row, lc, addr, qq, gr;
        logic hs, vs, win, pix;
        logic [8:0] d;
        logic [7:0] g;
        logic [10:0] ca;
        if (nn < 4) return {1'b0, ~POLB, ~POLB, 1'b1, 1'b0};
        p   = nn - 4;
        f   = p / FRAME;
        r   = p % FRAME;
        v   = r / HT;
        h   = r % HT;
        hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
        win = (h >= HB) && (h < HB + WW) && (v >= VB) && (v < VB + WH);
        pix = 1'b0;
        if (win) begin
            col  = ((h - HB) >> HS) / 8;
            x    = ((h - HB) >> HS) % 8;
            row  = (v - VB) / LPC;
            lc   = (v - VB) % LPC;
            addr = row * COLS + col;
            d    = vram[addr];
            if (d[8]) begin
                qq  = (lc * 4) / LPC;
                pix = d[2 * qq + ((x >= 4) ? 1 : 0)];
            end else begin
                gr  = (lc >> VS) % 16;
                ca  = {d[6:0], 4'(gr)};
                g   = crom[ca];
                pix = g[7 - x];
            end
            if (hist_en[p] && ((f / BF) % 2 == 1) && int'(hist_pos[p]) == addr)
                pix = ~pix;
        end
        return {pix, POLB ? hs : ~hs, POLB ? vs : ~vs, ~(hs ^ vs), (r == 0)};
    endfunction

    task automatic check_all();
        logic [4:0] e;
        e = model(n);
        cmp("video", video, e[4]);
        cmp("hsync", hsync, e[3]);
        cmp("vsync", vsync, e[2]);
        cmp("csync", csync, e[1]);
        cmp("frame_start", frame_start, e[0]);
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_video"}, video, 1'b0);
        cmp({tag, "_hsync"}, hsync, ~POLB);
        cmp({tag, "_vsync"}, vsync, ~POLB);
        cmp({tag, "_csync"}, csync, 1'b1);
        cmp({tag, "_fs"}, frame_start, 1'b0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) vram[i] = 9'($urandom);
        for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        n     = 0;
        mpos  = '0;
        men   = 1'b0;
        hist_pos[0] = '0;
        hist_en[0]  = 1'b0;
        check_all();
    endtask

    task automatic step();
        @(posedge clk);
        if (n < NMAX) n++;
        if (cur_we) begin
            mpos = cur_pos;
            men  = cur_en;
        end
        hist_pos[n] = mpos;
        hist_en[n]  = men;
        @(negedge clk);
        check_all();
        cur_we = 1'b0;
        if ($urandom_range(0, 599) == 0) begin
            cur_we  = 1'b1;
            cur_pos = AW'($urandom_range(0, COLS * ROWS - 1));
            cur_en  = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        cur_we  = 1'b0;
        cur_pos = '0;
        cur_en  = 1'b0;
        n       = 0;
        fill_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_init");
        release_reset();

        cur_we  = 1'b1;
        cur_pos = AW'(5);
        cur_en  = 1'b1;
        repeat (5 * FRAME + 650) step();

        cur_we = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        fill_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        release_reset();
        repeat (3 * FRAME) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
